muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the processor's integer multiply/divide resource and its HI/LO register pair. It accepts mult/multu/div/divu commands from decode and runs an iterative radix-2 shift-add multiplier or restoring divider over 34 cycles. It owns HI and LO, and serves mfhi/mflo reads. It stalls the pipeline when a read arrives before the current operation has finished.

## Interface
Parameters:
- none (width fixed at 32, iteration count fixed at 32)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- start  in  1  command valid; sampled only in IDLE
- op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- mfhi_req  in  1  read HI this cycle
- mflo_req  in  1  read LO this cycle
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse after HI/LO are written
- stall  out  1  read request cannot be served this cycle
- rd_data  out  32  HI or LO value for the read
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE:
  - start=1 latches op, a, b and goes to PREP.
  - start=0 stays in IDLE.
- PREP (1 cycle):
  - For signed ops, convert operands to absolute value (32-bit wrap, so 0x80000000 stays 0x80000000).
  - Record result sign(s).
  - Clear the 64-bit accumulator and the 5-bit counter.
  - Go to RUN.
- RUN (32 cycles):
  - Multiply: each cycle, if the accumulator LSB is set, add the multiplicand to the upper half, then shift the 65-bit {carry, acc} right by 1.
  - Divide (restoring): shift {rem, quo} left 1, trial-subtract the divisor from rem; if non-negative keep the difference and set the quotient LSB.
  - Counter increments each cycle; at count 31, go to FIX.
- FIX (1 cycle), then IDLE:
  - Multiply: if the result sign is negative, negate the 64-bit product. HI=product[63:32], LO=product[31:0].
  - Divide: if the operand signs differ, negate the quotient; if the dividend is negative, negate the remainder. LO=quotient, HI=remainder.
  - Divide by zero (b==0, either signedness): HI=a (original, unmodified), LO=32'hFFFFFFFF. The full latency is still spent.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- Commands are never queued. start outside IDLE is ignored, with no error flag; decode must hold the instruction while busy.
- Reads:
  - If mfhi_req or mflo_req is high while busy=1: stall=1 and rd_data=0.
  - When busy=0: stall=0 and rd_data = HI (mfhi_req) or LO (mflo_req). mfhi_req wins if both are high.
  - No request: rd_data=0.
  - stall and rd_data are combinational from state and registers.
- Simultaneous start and read in IDLE: the read returns the pre-command HI/LO with stall=0, and start is accepted.

## Timing
- Reset (async assert, synchronous release by the system):
  - state=IDLE; HI=0, LO=0.
  - busy=0, done=0, stall=0, rd_data=0.
  - Internal accumulator and counter cleared.
- Reset asserted mid-operation aborts the operation immediately; HI/LO return to 0 and no done pulse is produced.
- Latency:
  - start sampled at edge E0.
  - PREP runs E0→E1; RUN runs E1→E33 (32 edges); FIX ends at E34.
  - HI/LO are written at E34.
  - done=1 for exactly the cycle after E34.
- busy is registered: high in the cycles following E0 through E34 (34 cycles), low in the cycle where done=1.
- A new start may be accepted in the done cycle, since state is IDLE.
- stall is deasserted in the done cycle, and a read in that cycle returns the new result.
- hi/lo outputs change only at the FIX edge or at reset.

## Test plan
- Reset, then a single cycle with mfhi_req=1 → stall=0, rd_data=0, busy=0, done=0.
- mult: a=0xFFFFFFFD (-3), b=5 → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; done pulses one cycle; busy high exactly 34 cycles.
- multu: a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then div: a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: a=100, b=0 → HI=0x00000064, LO=0xFFFFFFFF. div: a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- mflo_req held from cycle 3 of a divu 17/5 → stall=1 and rd_data=0 through cycle 34; in the done cycle stall=0 and rd_data=3. A second start issued at cycle 10 is ignored, and HI ends at 2.
- Reset asserted at cycle 20 of a mult after prior HI=0x1234 → HI=LO=0 and busy=0 immediately. After release no done pulse occurs, and a fresh start completes normally.

Source files
------------

// File: rtl/muldiv_if.sv
// Decode <-> multiply/divide sequencer bundle.
// Command, HI/LO read request and status signals.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mfhi_req;
  logic        mflo_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    output mfhi_req, mflo_req,
    input  busy, done, stall,
    input  rd_data, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  mfhi_req, mflo_req,
    output busy, done, stall,
    output rd_data, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide unit
// owning the HI/LO pair; 34-cycle latency per command.
module muldiv_sequencer (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, PREP, RUN, FIX
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] m_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic        rneg_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_div;
  logic        is_sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [63:0] acc_d;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] rd;

  assign is_div = op_q[1];
  assign is_sgn = ~op_q[0];

  assign abs_a = (is_sgn & a_q[31]) ? -a_q : a_q;
  assign abs_b = (is_sgn & b_q[31]) ? -b_q : b_q;

  // Multiply: add into upper half, carry shifts back in.
  assign sum = {1'b0, acc_q[63:32]}
             + (acc_q[0] ? {1'b0, m_q} : 33'd0);

  // Divide: {rem, quo} << 1, then trial subtract.
  assign rem_sh = acc_q[63:31];
  assign diff   = {1'b0, rem_sh} - {2'b00, m_q};

  always_comb begin
    acc_d = {sum, acc_q[31:1]};
    if (is_div) begin
      if (diff[33])
        acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
      else
        acc_d = {diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quo  = neg_q  ? -acc_q[31:0] : acc_q[31:0];
  assign rem  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          m_q     <= abs_b;
          acc_q   <= {32'h0, abs_a};
          cnt_q   <= '0;
          neg_q   <= is_sgn & (a_q[31] ^ b_q[31]);
          rneg_q  <= is_sgn & a_q[31];
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31)
            state_q <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end else if (b_q == 32'h0) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    priority case (1'b1)
      busy_q:       rd = '0;
      bus.mfhi_req: rd = hi_q;
      bus.mflo_req: rd = lo_q;
      default:      rd = '0;
    endcase
  end

  assign bus.stall   = busy_q & (bus.mfhi_req | bus.mflo_req);
  assign bus.rd_data = rd;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against
// an arithmetic reference model of HI/LO results.
module tb_muldiv_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  muldiv_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(
    input logic [1:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    res = '0;
    case (o)
      2'd0: res = 64'(sx * sy);
      2'd1: res = ux * uy;
      2'd2: begin
        if (y == 0)
          res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          res = {32'h0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0)
          res = {x, 32'hFFFF_FFFF};
        else begin
          res[31:0]  = 32'(ux / uy);
          res[63:32] = 32'(ux % uy);
        end
      end
    endcase
    return res;
  endfunction

  // Drives a command for one edge; returns in cycle 1.
  task automatic issue(
    input logic [1:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs until done (bounded); reports busy cycles seen.
  task automatic wait_done(
    output int nb,
    output bit ok,
    output bit stable
  );
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    nb = 0;
    stable = 1'b1;
    for (int c = 0; c < 60 && !bus.done; c++) begin
      if (bus.busy) nb++;
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
      @(negedge clk);
    end
    ok = bus.done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.mfhi_req = 0; bus.mflo_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mfhi_req = 1'b1;
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall);
    end
    n_chk++;
    if (bus.rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd got %h exp 0", bus.rd_data);
    end
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done);
    end
    n_chk++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_hilo got %h_%h exp 0", bus.hi, bus.lo);
    end
    bus.mfhi_req = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'd100, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'h8000_0000};
    logic [31:0] bs  [7] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0,
                             32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    logic [63:0] e;
    int nb; bit ok, st;
    for (int i = 0; i < 7; i++) begin
      e = model(ops[i], as[i], bs[i]);
      issue(ops[i], as[i], bs[i]);
      wait_done(nb, ok, st);
      n_chk++;
      if (!ok) begin
        n_fail++; $display("FAIL dir%0d_timeout got no done exp done", i);
      end
      n_chk++;
      if (nb != 34) begin
        n_fail++; $display("FAIL dir%0d_busy got %0d exp 34", i, nb);
      end
      n_chk++;
      if (bus.hi !== e[63:32] || bus.lo !== e[31:0]) begin
        n_fail++;
        $display("FAIL dir%0d_hilo got %h_%h exp %h_%h",
                 i, bus.hi, bus.lo, e[63:32], e[31:0]);
      end
      n_chk++;
      if (bus.busy !== 1'b0 || !st) begin
        n_fail++;
        $display("FAIL dir%0d_idle busy %b stable %b exp 0 1",
                 i, bus.busy, st);
      end
      @(negedge clk);
      n_chk++;
      if (bus.done !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_pulse got %b exp 0", i, bus.done);
      end
    end
  endtask

  task automatic test_read_stall;
    issue(2'd3, 32'd17, 32'd5);
    for (int k = 1; k <= 35; k++) begin
      if (k == 3) bus.mflo_req = 1'b1;
      if (k == 10) begin
        bus.start = 1'b1; bus.op = 2'd1;
        bus.a = 32'd7; bus.b = 32'd7;
      end
      if (k == 11) bus.start = 1'b0;
      #1;
      if (k >= 3 && k <= 34) begin
        n_chk++;
        if (bus.stall !== 1'b1 || bus.rd_data !== 32'h0) begin
          n_fail++;
          $display("FAIL stall_c%0d got %b/%h exp 1/0",
                   k, bus.stall, bus.rd_data);
        end
      end
      if (k == 35) begin
        n_chk++;
        if (bus.done !== 1'b1 || bus.stall !== 1'b0
            || bus.rd_data !== 32'd3) begin
          n_fail++;
          $display("FAIL stall_done got %b/%b/%h exp 1/0/3",
                   bus.done, bus.stall, bus.rd_data);
        end
      end
      @(negedge clk);
    end
    bus.mflo_req = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd2) begin
      n_fail++;
      $display("FAIL ignored_start got busy %b hi %h exp 0 2",
               bus.busy, bus.hi);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e1, e2;
    int nb; bit ok, st;
    e1 = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    e2 = model(2'd2, 32'hFFFF_FF00, 32'd7);
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(nb, ok, st);
    bus.start = 1'b1; bus.op = 2'd2;
    bus.a = 32'hFFFF_FF00; bus.b = 32'd7;
    bus.mfhi_req = 1'b1; bus.mflo_req = 1'b1;
    #1;
    n_chk++;
    if (!ok || bus.stall !== 1'b0 || bus.rd_data !== e1[63:32]) begin
      n_fail++;
      $display("FAIL b2b_read got ok %b stall %b rd %h exp 1 0 %h",
               ok, bus.stall, bus.rd_data, e1[63:32]);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.mfhi_req = 1'b0; bus.mflo_req = 1'b0;
    wait_done(nb, ok, st);
    n_chk++;
    if (!ok || nb != 34 || bus.hi !== e2[63:32]
        || bus.lo !== e2[31:0]) begin
      n_fail++;
      $display("FAIL b2b_second got ok %b busy %0d %h_%h exp 1 34 %h_%h",
               ok, nb, bus.hi, bus.lo, e2[63:32], e2[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nb, pulses; bit ok, st;
    issue(2'd3, 32'h0000_1234, 32'h0001_0000);
    wait_done(nb, ok, st);
    n_chk++;
    if (!ok || bus.hi !== 32'h1234) begin
      n_fail++; $display("FAIL rmid_prior got hi %h exp 1234", bus.hi);
    end
    issue(2'd0, 32'd3, 32'd4);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_abort got %h_%h busy %b exp 0_0 0",
               bus.hi, bus.lo, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    n_chk++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL rmid_nodone got %0d exp 0", pulses);
    end
    issue(2'd0, 32'hFFFF_FFF0, 32'd9);
    wait_done(nb, ok, st);
    n_chk++;
    if (!ok || nb != 34 || bus.hi !== 32'hFFFF_FFFF
        || bus.lo !== 32'hFFFF_FF70) begin
      n_fail++;
      $display("FAIL rmid_fresh got %h_%h busy %0d exp ffffffff_ffffff70 34",
               bus.hi, bus.lo, nb);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] x, y, exp_rd;
    logic [63:0] e;
    int nb, sel; bit ok, st;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'h0;
      if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (sel == 2) y = 32'hFFFF_FFFF;
      if (sel == 3) begin x = x % 100; y = y % 10; end
      e = model(o, x, y);
      issue(o, x, y);
      wait_done(nb, ok, st);
      if (i % 2 == 0) begin
        bus.mfhi_req = 1'b1; exp_rd = e[63:32];
      end else begin
        bus.mflo_req = 1'b1; exp_rd = e[31:0];
      end
      #1;
      n_chk++;
      if (!ok || nb != 34 || !st) begin
        n_fail++;
        $display("FAIL rnd%0d_timing got ok %b busy %0d stable %b exp 1 34 1",
                 i, ok, nb, st);
      end
      n_chk++;
      if (bus.hi !== e[63:32] || bus.lo !== e[31:0]) begin
        n_fail++;
        $display("FAIL rnd%0d_hilo op %0d a %h b %h got %h_%h exp %h_%h",
                 i, o, x, y, bus.hi, bus.lo, e[63:32], e[31:0]);
      end
      n_chk++;
      if (bus.stall !== 1'b0 || bus.rd_data !== exp_rd) begin
        n_fail++;
        $display("FAIL rnd%0d_read got %b/%h exp 0/%h",
                 i, bus.stall, bus.rd_data, exp_rd);
      end
      @(negedge clk);
      bus.mfhi_req = 1'b0;
      bus.mflo_req = 1'b0;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_read_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
